decode_ctrl: RTL and testbench

- Second-generation RV32I decode/control unit, between fetch and the register file/ALU/LSU.
- Latches the instruction on a fetch request and decodes all RV32I base formats (R/I/S/B/U/J): SUB/SRA, unsigned compares, zero-extending loads.
- Sequences execution through a registered FSM with an LSU handshake and a bus-timeout counter.
- Flags illegal opcodes to fetch instead of silently executing them.

---
 rtl/decode_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// RV32I decode/control unit: latches an instruction from fetch, decodes it and sequences
// execution through EXEC, a PC-update step or an LSU handshake guarded by a bus timeout.
module decode_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_CONTROL_BITS = 4,
  parameter int LOG2_REGISTERS   = 5,
  parameter int BYTE_DATA_WIDTH  = 4,
  parameter int MEM_TIMEOUT      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       inst,
  input  logic                        compute_req,
  output logic                        compute_valid,
  output logic                        trap,
  output logic                        branch_flag,
  output logic                        mem_req,
  output logic                        mem_we,
  input  logic                        mem_valid,
  output logic [BYTE_DATA_WIDTH-1:0]  mem_byte_enable,
  output logic                        mem_unsigned,
  input  logic [1:0]                  addr_lsb,
  output logic [LOG2_REGISTERS-1:0]   addr_rd,
  output logic [LOG2_REGISTERS-1:0]   addr_rs1,
  output logic [LOG2_REGISTERS-1:0]   addr_rs2,
  output logic [1:0]                  rd_select,
  output logic                        rf_enable,
  output logic [DATA_WIDTH-1:0]       direct_store,
  input  logic                        less_comp,
  input  logic                        less_u_comp,
  input  logic                        equal_comp,
  output logic [ALU_CONTROL_BITS-1:0] alu_control,
  output logic                        signed_flag,
  output logic [DATA_WIDTH-1:0]       imm,
  output logic                        select_imm,
  output logic                        select_pc
);

  localparam logic [2:0] IDLE = 3'd0, EXEC = 3'd1, PC_UPD = 3'd2,
                         MEM_REQ = 3'd3, MEM_WAIT = 3'd4, DONE = 3'd5;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  localparam logic [ALU_CONTROL_BITS-1:0]
    ALU_ADD = ALU_CONTROL_BITS'(0), ALU_SUB = ALU_CONTROL_BITS'(1), ALU_SLL = ALU_CONTROL_BITS'(2),
    ALU_SLT = ALU_CONTROL_BITS'(3), ALU_SLTU = ALU_CONTROL_BITS'(4), ALU_XOR = ALU_CONTROL_BITS'(5),
    ALU_SRL = ALU_CONTROL_BITS'(6), ALU_SRA = ALU_CONTROL_BITS'(7), ALU_OR = ALU_CONTROL_BITS'(8),
    ALU_AND = ALU_CONTROL_BITS'(9);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  trap_q, trap_d;
  logic                  branch_q, branch_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic is_reg, is_imm_op, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  logic is_cmp, legal, misaligned, branch_cond, writes_rf;
  logic [ALU_CONTROL_BITS-1:0] alu_op;

  always_comb begin
    opcode    = inst_q[6:0];
    funct3    = inst_q[14:12];
    funct7    = inst_q[31:25];
    is_reg    = (opcode == OP_REG);
    is_imm_op = (opcode == OP_IMM);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_cmp    = (is_reg || is_imm_op) && (funct3[2:1] == 2'b01);
    writes_rf = is_reg || is_imm_op || is_lui || is_auipc || is_jal || is_jalr;
    misaligned = ((funct3[1:0] == 2'b01) && (addr_lsb == 2'b11)) ||
                 ((funct3[1:0] == 2'b10) && (addr_lsb != 2'b00));

    case (opcode)
      OP_REG:    legal = (funct7 == 7'b0) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_IMM:    legal = (funct3 == 3'b001) ? (funct7 == 7'b0) :
                         (funct3 == 3'b101) ? ((funct7 == 7'b0) || (funct7 == 7'b0100000)) : 1'b1;
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OP_STORE:  legal = (funct3 < 3'b011);
      OP_BRANCH: legal = (funct3[2:1] != 2'b01);
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      default:   legal = 1'b0;
    endcase

    case (funct3)
      3'b000:  branch_cond = equal_comp;
      3'b001:  branch_cond = !equal_comp;
      3'b100:  branch_cond = less_comp;
      3'b101:  branch_cond = !less_comp;
      3'b110:  branch_cond = less_u_comp;
      3'b111:  branch_cond = !less_u_comp;
      default: branch_cond = 1'b0;
    endcase

    // funct7[5] doubles as imm[10] for SRAI, so one bit selects SUB/SRA for both formats.
    alu_op = ALU_ADD;
    if (is_reg || is_imm_op) begin
      case (funct3)
        3'b000:  alu_op = (is_reg && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end

    case (opcode)
      OP_STORE:        imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      OP_BRANCH:       imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {inst_q[31:12], 12'b0};
      OP_JAL:          imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      default:         imm = {{20{inst_q[31]}}, inst_q[31:20]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    count_d  = '0;
    trap_d   = trap_q;
    branch_d = branch_q;
    case (state_q)
      IDLE: begin
        trap_d   = 1'b0;
        branch_d = 1'b0;
        if (compute_req) begin
          inst_d  = inst;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!legal || ((is_load || is_store) && misaligned)) begin
          trap_d  = 1'b1;
          state_d = DONE;
        end else if (is_load || is_store) begin
          state_d = MEM_REQ;
        end else if (is_branch || is_jal || is_jalr) begin
          state_d = PC_UPD;
        end else begin
          state_d = DONE;
        end
      end
      PC_UPD: begin
        branch_d = is_branch ? branch_cond : 1'b1;
        state_d  = DONE;
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        // A completion arriving on the last allowed cycle still beats the timeout.
        if (mem_valid) begin
          state_d = DONE;
        end else if (count_q == CNT_LAST) begin
          trap_d  = 1'b1;
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        trap_d   = 1'b0;
        branch_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      inst_q   <= NOP;
      count_q  <= '0;
      trap_q   <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      count_q  <= count_d;
      trap_q   <= trap_d;
      branch_q <= branch_d;
    end
  end

  // Strobes are masked by rst so an aborted instruction never leaks a request or retirement.
  always_comb begin
    compute_valid = !rst && (state_q == DONE);
    trap          = compute_valid && trap_q;
    branch_flag   = branch_q;
    mem_req       = !rst && (state_q == MEM_REQ);
    mem_we        = !rst && is_store && ((state_q == MEM_REQ) || (state_q == MEM_WAIT));
    rf_enable     = !rst && (((state_q == EXEC) && legal && writes_rf) ||
                             ((state_q == MEM_WAIT) && mem_valid && is_load));
    mem_unsigned  = is_load && funct3[2];
    mem_byte_enable = '0;
    if (is_load || is_store) begin
      case (funct3[1:0])
        2'b00:   mem_byte_enable = BYTE_DATA_WIDTH'(4'b0001 << addr_lsb);
        2'b01:   mem_byte_enable = BYTE_DATA_WIDTH'(4'b0011 << addr_lsb);
        default: mem_byte_enable = BYTE_DATA_WIDTH'(4'b1111);
      endcase
    end
    addr_rd      = LOG2_REGISTERS'(inst_q[11:7]);
    addr_rs1     = is_lui ? '0 : LOG2_REGISTERS'(inst_q[19:15]);
    addr_rs2     = LOG2_REGISTERS'(inst_q[24:20]);
    rd_select    = is_load ? 2'd2 : (is_jal || is_jalr) ? 2'd3 : is_cmp ? 2'd1 : 2'd0;
    direct_store = {{(DATA_WIDTH-1){1'b0}}, is_cmp && (funct3[0] ? less_u_comp : less_comp)};
    alu_control  = alu_op;
    signed_flag  = (is_cmp && !funct3[0]) || (is_branch && (funct3[2:1] == 2'b10));
    select_imm   = (state_q == PC_UPD) ? 1'b1 : !(is_reg || is_branch);
    select_pc    = (state_q == PC_UPD) ? !is_jalr : is_auipc;
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Randomized self-checking bench for decode_ctrl; expectations come from an instruction-level
// model of retirement latency, writeback, memory handshake and trap behaviour.
module tb_decode_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        compute_req, compute_valid, trap, branch_flag;
  logic        mem_req, mem_we, mem_valid, mem_unsigned;
  logic [3:0]  mem_byte_enable;
  logic [1:0]  addr_lsb, rd_select;
  logic [4:0]  addr_rd, addr_rs1, addr_rs2;
  logic        rf_enable, less_comp, less_u_comp, equal_comp, signed_flag;
  logic [31:0] direct_store, imm;
  logic [3:0]  alu_control;
  logic        select_imm, select_pc;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  decode_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .inst(inst), .compute_req(compute_req),
    .compute_valid(compute_valid), .trap(trap), .branch_flag(branch_flag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_valid(mem_valid),
    .mem_byte_enable(mem_byte_enable), .mem_unsigned(mem_unsigned), .addr_lsb(addr_lsb),
    .addr_rd(addr_rd), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .rd_select(rd_select),
    .rf_enable(rf_enable), .direct_store(direct_store), .less_comp(less_comp),
    .less_u_comp(less_u_comp), .equal_comp(equal_comp), .alu_control(alu_control),
    .signed_flag(signed_flag), .imm(imm), .select_imm(select_imm), .select_pc(select_pc)
  );

  typedef struct packed {
    logic legal, trap, rf, mem_req, mem_we, mem_uns, branch, is_ctl, sel_pc;
    logic is_cmp, cmp_res, chk_alu, chk_imm, chk_sel_imm, sel_imm;
    logic [31:0] done_cycle, rf_cycle, rd_sel, alu, imm, be;
  } expect_t;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int aluBase(input int f3);
    case (f3)
      0: return 0;  1: return 2;  2: return 3;  3: return 4;
      4: return 5;  5: return 6;  6: return 8;  default: return 9;
    endcase
  endfunction

  function automatic logic branchTaken(input int f3, input logic lt, input logic ltu, input logic eq);
    case (f3)
      0: return eq;   1: return !eq;
      4: return lt;   5: return !lt;
      6: return ltu;  7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Cycle indices count from the accept cycle (0); compute_valid is expected at done_cycle.
  function automatic expect_t modelExpect(input logic [31:0] ins, input logic lt, input logic ltu,
                                          input logic eq, input int lsb, input int delay);
    expect_t e;
    int op, f3, f7, size, w, raw;
    e  = '0;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    case (op)
      'h33: e.legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      'h13: e.legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1;
      'h03: e.legal = (f3 inside {0, 1, 2, 4, 5});
      'h23: e.legal = (f3 <= 2);
      'h63: e.legal = !(f3 inside {2, 3});
      'h67: e.legal = (f3 == 0);
      'h37, 'h17, 'h6F: e.legal = 1'b1;
      default: e.legal = 1'b0;
    endcase
    case (op)
      'h23: begin raw = f7 * 32 + int'(ins[11:7]); if (ins[31]) raw -= 4096; end
      'h63: begin
        raw = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) raw -= 8192;
      end
      'h6F: begin
        raw = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) raw -= 2097152;
      end
      default: begin raw = int'(ins[31:20]); if (ins[31]) raw -= 4096; end
    endcase
    e.imm = (op == 'h37 || op == 'h17) ? (ins & 32'hFFFF_F000) : 32'(raw);
    e.chk_imm = e.legal && (op != 'h33);
    e.chk_sel_imm = e.legal && (op inside {'h33, 'h13, 'h03, 'h23, 'h37, 'h17});
    e.sel_imm = (op != 'h33);
    if (op == 'h33 || op == 'h13) begin
      e.chk_alu = e.legal;
      e.alu = 32'(aluBase(f3) + ((f7 == 'h20 && (f3 == 5 || (f3 == 0 && op == 'h33))) ? 1 : 0));
      e.is_cmp = e.legal && (f3 == 2 || f3 == 3);
      e.cmp_res = (f3 == 2) ? lt : ltu;
    end
    if (!e.legal) begin
      e.trap = 1'b1;
      e.done_cycle = 2;
    end else begin
      case (op)
        'h63: begin
          e.done_cycle = 3; e.is_ctl = 1'b1; e.sel_pc = 1'b1;
          e.branch = branchTaken(f3, lt, ltu, eq);
        end
        'h6F, 'h67: begin
          e.done_cycle = 3; e.is_ctl = 1'b1; e.sel_pc = (op == 'h6F); e.branch = 1'b1;
          e.rf = 1'b1; e.rf_cycle = 1; e.rd_sel = 3;
        end
        'h03, 'h23: begin
          size = f3 % 4;
          if ((size == 1 && lsb == 3) || (size == 2 && lsb != 0)) begin
            e.trap = 1'b1;
            e.done_cycle = 2;
          end else begin
            e.mem_req = 1'b1;
            e.mem_we  = (op == 'h23);
            e.mem_uns = (op == 'h03) && (f3 >= 4);
            e.be = 32'((((1 << (1 << size)) - 1) << lsb) & 15);
            if (delay >= 1 && delay <= MEM_TIMEOUT) w = delay;
            else begin w = MEM_TIMEOUT; e.trap = 1'b1; end
            e.done_cycle = 32'(3 + w);
            if (op == 'h03 && !e.trap) begin e.rf = 1'b1; e.rf_cycle = 32'(2 + w); e.rd_sel = 2; end
          end
        end
        default: begin
          e.done_cycle = 2; e.rf = 1'b1; e.rf_cycle = 1; e.rd_sel = e.is_cmp ? 1 : 0;
        end
      endcase
    end
    return e;
  endfunction

  // Runs one instruction; delay = cycles from mem_req to mem_valid, 0 = never.
  task automatic applyStimulus(input logic [31:0] ins, input logic lt, input logic ltu, input logic eq,
                               input int lsb, input int delay, input logic drop_req);
    expect_t e;
    int done_cyc, rf_cnt, rf_cyc, rd_sel, req_cnt, req_cyc;
    logic [31:0] alu_obs, imm_obs, dstore_obs;
    logic [3:0] be_obs;
    logic we_obs, uns_obs, pc_obs, immsel_obs, immsel_exec, br_obs, trap_obs;
    e = modelExpect(ins, lt, ltu, eq, lsb, delay);
    done_cyc = -1; rf_cnt = 0; rf_cyc = -1; rd_sel = -1; req_cnt = 0; req_cyc = -1;
    alu_obs = '0; imm_obs = '0; dstore_obs = '0; be_obs = '0;
    we_obs = 0; uns_obs = 0; pc_obs = 0; immsel_obs = 0; immsel_exec = 0; br_obs = 0; trap_obs = 0;
    @(negedge clk);
    inst = ins; less_comp = lt; less_u_comp = ltu; equal_comp = eq;
    addr_lsb = 2'(lsb); mem_valid = 1'b0; compute_req = 1'b1;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      inst = $urandom();
      if (drop_req && cyc == 1) compute_req = 1'b0;
      mem_valid = (req_cyc > 0) && (delay > 0) && (cyc == req_cyc + delay);
      #1;
      if (cyc == 1) begin
        alu_obs = 32'(alu_control); imm_obs = imm; dstore_obs = direct_store; immsel_exec = select_imm;
      end
      if (cyc == 2) begin pc_obs = select_pc; immsel_obs = select_imm; end
      if (mem_req) begin
        req_cnt++; req_cyc = cyc; be_obs = mem_byte_enable; we_obs = mem_we; uns_obs = mem_unsigned;
      end
      if (rf_enable) begin rf_cnt++; rf_cyc = cyc; rd_sel = int'(rd_select); end
      if (compute_valid) begin done_cyc = cyc; trap_obs = trap; br_obs = branch_flag; end
    end
    compute_req = 1'b0;
    mem_valid = 1'b0;
    checkOutput($sformatf("latency[%08h]", ins), 32'(done_cyc), e.done_cycle);
    checkOutput("trap", 32'(trap_obs), 32'(e.trap));
    checkOutput("branch_flag", 32'(br_obs), 32'(e.branch));
    checkOutput("rf_enable_count", 32'(rf_cnt), 32'(e.rf));
    if (e.rf) begin
      checkOutput("rf_cycle", 32'(rf_cyc), e.rf_cycle);
      checkOutput("rd_select", 32'(rd_sel), e.rd_sel);
    end
    checkOutput("mem_req_count", 32'(req_cnt), 32'(e.mem_req));
    if (e.mem_req) begin
      checkOutput("mem_req_cycle", 32'(req_cyc), 32'd2);
      checkOutput("mem_byte_enable", 32'(be_obs), e.be);
      checkOutput("mem_we", 32'(we_obs), 32'(e.mem_we));
      checkOutput("mem_unsigned", 32'(uns_obs), 32'(e.mem_uns));
    end
    if (e.chk_alu) checkOutput("alu_control", alu_obs, e.alu);
    if (e.chk_imm) checkOutput("imm", imm_obs, e.imm);
    if (e.chk_sel_imm) checkOutput("select_imm_exec", 32'(immsel_exec), 32'(e.sel_imm));
    if (e.is_cmp) checkOutput("direct_store", dstore_obs, 32'(e.cmp_res));
    if (e.is_ctl) begin
      checkOutput("select_pc", 32'(pc_obs), 32'(e.sel_pc));
      checkOutput("select_imm_pc_upd", 32'(immsel_obs), 32'd1);
    end
    @(negedge clk);
    #1;
    checkOutput("idle_no_valid", 32'(compute_valid), 32'd0);
  endtask

  // Starts a word load that never completes and aborts it with reset at the given cycle.
  task automatic resetMidOp(input int reset_at);
    int stray;
    @(negedge clk);
    inst = 32'h0000_A283; addr_lsb = 2'd0; mem_valid = 1'b0; compute_req = 1'b1;
    repeat (reset_at) @(negedge clk);
    #1;
    checkOutput("pre_reset_mem_req", 32'(mem_req), 32'(reset_at == 2));
    rst = 1'b1;
    compute_req = 1'b0;
    #1;
    checkOutput("reset_mem_req_drop", 32'(mem_req), 32'd0);
    checkOutput("reset_no_valid", 32'(compute_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_strobes",
                {26'b0, compute_valid, trap, branch_flag, mem_req, mem_we, rf_enable}, 32'd0);
    checkOutput("post_reset_imm", imm, 32'd0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (compute_valid || mem_req || rf_enable) stray++;
    end
    checkOutput("post_reset_quiet", 32'(stray), 32'd0);
  endtask

  initial begin
    logic [31:0] ins;
    int kind;
    rst = 1'b1; inst = '0; compute_req = 1'b0; mem_valid = 1'b0; addr_lsb = '0;
    less_comp = 1'b0; less_u_comp = 1'b0; equal_comp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_strobes",
                {26'b0, compute_valid, trap, branch_flag, mem_req, mem_we, rf_enable}, 32'd0);
    checkOutput("reset_alu_control", 32'(alu_control), 32'd0);
    checkOutput("reset_imm", imm, 32'd0);
    checkOutput("reset_select_imm", 32'(select_imm), 32'd1);
    checkOutput("reset_regs", {17'b0, addr_rd, addr_rs1, addr_rs2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h402081B3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(32'h4042D293, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(32'h0020E463, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(32'h0020E463, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(32'h0000C283, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0);
    applyStimulus(32'h0020A023, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(32'h0020A023, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
    applyStimulus(32'h0000A283, 1'b0, 1'b0, 1'b0, 0, MEM_TIMEOUT, 1'b0);
    applyStimulus(32'h0000007F, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    resetMidOp(5);
    resetMidOp(2);

    for (int n = 0; n < 150; n++) begin
      ins  = $urandom();
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: begin
          ins[6:0] = 7'h33;
          ins[31:25] = ($urandom_range(0, 3) == 0) ? 7'($urandom()) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
        end
        1: begin
          ins[6:0] = 7'h13;
          if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        end
        2: ins[6:0] = 7'h03;
        3: ins[6:0] = 7'h23;
        4: ins[6:0] = 7'h63;
        5: ins[6:0] = 7'h37;
        6: ins[6:0] = 7'h17;
        7: ins[6:0] = 7'h6F;
        8: begin ins[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b000; end
        default: ins[6:0] = 7'($urandom());
      endcase
      applyStimulus(ins, 1'($urandom()), 1'($urandom()), 1'($urandom()),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, MEM_TIMEOUT + 2)),
                    1'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
